// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_pkg
//  Brief    : Shared scan-state encoding and constant helpers for the
//             seven-segment digit-scan sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Level of an undriven digit-select line for the chosen polarity.
    function automatic logic sel_off_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : scan_prescaler
//  Brief    : Free-running 0..DIV-1 divider producing a one-cycle scan tick.
//  Revision : 1.0  initial release
// ============================================================================
module scan_prescaler
    import seg_scan_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_last);
    assign o_tick = i_run & w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dynamic_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dynamic_scan_counter
//  Brief    : Digit-scan sequencer for multiplexed seven-segment displays with
//             masked digit skipping and an all-off blanking gap.
//  Revision : 1.0  initial release
// ============================================================================
module dynamic_scan_counter
    import seg_scan_pkg::*;
#(
    parameter  int DIGITS      = 4,
    parameter  int DIV         = 50000,
    parameter  int BLANK_TICKS = 1,
    parameter  int ACTIVE_LOW  = 1,
    localparam int IDX_W       = (DIGITS > 1) ? clog2(DIGITS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DIGITS-1:0] i_digit_en,
    output logic [IDX_W-1:0]  o_s_idx,
    output logic [DIGITS-1:0] o_digit_sel,
    output logic              o_blank,
    output logic              o_frame
);

    localparam int                  c_gap_w    = (BLANK_TICKS > 1) ? clog2(BLANK_TICKS) : 1;
    localparam logic [c_gap_w-1:0]  c_gap_last = c_gap_w'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [DIGITS-1:0]   c_sel_off  = {DIGITS{sel_off_level(ACTIVE_LOW)}};

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_first;
    logic [IDX_W-1:0]   w_adv;
    logic [c_gap_w-1:0] r_gap;
    logic [c_gap_w-1:0] w_gap_nxt;
    logic [DIGITS-1:0]  w_onehot;
    logic [DIGITS-1:0]  w_sel_on;
    logic               w_go;
    logic               w_tick;
    logic               w_clr;
    logic               w_run;
    logic               w_frame_nxt;
    int                 w_best;

    // Steps, counting upward with wrap, from one digit to another.
    function automatic int dist_from(input int from, input int to);
        return (to > from) ? (to - from - 1) : (to + DIGITS - from - 1);
    endfunction

    assign w_go  = i_en & (|i_digit_en);
    assign w_run = (r_state != ST_IDLE);

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_run  (w_run),
        .o_tick (w_tick)
    );

    always_comb begin
        w_first = '0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            if (i_digit_en[j]) begin
                w_first = IDX_W'(j);
            end
        end
    end

    // Rotate the mask so the search starts just above the current digit and
    // take the nearest enabled one; a lone enabled digit wraps back to itself.
    always_comb begin
        w_adv  = r_idx;
        w_best = DIGITS;
        for (int j = 0; j < DIGITS; j++) begin
            if (i_digit_en[j] && (dist_from(int'(r_idx), j) < w_best)) begin
                w_best = dist_from(int'(r_idx), j);
                w_adv  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_clr       = 1'b0;
        w_frame_nxt = 1'b0;
        if (!w_go) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ON;
                    w_idx_nxt   = w_first;
                    w_clr       = 1'b1;
                    w_frame_nxt = 1'b1;
                end
                ST_ON: begin
                    if (w_tick) begin
                        w_idx_nxt   = w_adv;
                        w_frame_nxt = (w_adv <= r_idx);
                        w_gap_nxt   = '0;
                        w_state_nxt = (BLANK_TICKS == 0) ? ST_ON : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_gap == c_gap_last) begin
                            w_state_nxt = ST_ON;
                        end else begin
                            w_gap_nxt = r_gap + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int j = 0; j < DIGITS; j++) begin
            if (int'(w_idx_nxt) == j) begin
                w_onehot[j] = 1'b1;
            end
        end
    end

    // A masked-off digit stays dark while its ON period keeps running.
    assign w_sel_on = w_onehot & i_digit_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_gap       <= '0;
            o_digit_sel <= c_sel_off;
            o_blank     <= 1'b1;
            o_frame     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_gap       <= w_gap_nxt;
            o_digit_sel <= (w_state_nxt == ST_ON) ? (w_sel_on ^ c_sel_off) : c_sel_off;
            o_blank     <= (w_state_nxt != ST_ON);
            o_frame     <= w_frame_nxt;
        end
    end

    assign o_s_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_dynamic_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dynamic_scan_counter
//  Brief    : Self-checking bench for dynamic_scan_counter in two configurations
//             against a cycle-level behavioural model of the scan rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dynamic_scan_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, blank_a, frame_a;
    logic [2:0] mask_a, sel_a;
    logic [1:0] idx_a;
    logic       rst_b, en_b, blank_b, frame_b;
    logic [3:0] mask_b, sel_b;
    logic [1:0] idx_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model configuration: index 0 = dut_a, 1 = dut_b.
    int c_digits [2] = '{3, 4};
    int c_div    [2] = '{1, 4};
    int c_bt     [2] = '{0, 1};
    int c_al     [2] = '{0, 1};

    // Model state: mode 0 idle, 1 digit lit, 2 gap; age = cycles into segment.
    int m_mode [2];
    int m_idx  [2];
    int m_age  [2];
    int m_sel  [2];
    bit m_frame[2];

    dynamic_scan_counter #(
        .DIGITS(3), .DIV(1), .BLANK_TICKS(0), .ACTIVE_LOW(0)
    ) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .i_digit_en(mask_a),
        .o_s_idx(idx_a), .o_digit_sel(sel_a), .o_blank(blank_a), .o_frame(frame_a)
    );

    dynamic_scan_counter #(
        .DIGITS(4), .DIV(4), .BLANK_TICKS(1), .ACTIVE_LOW(1)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .i_digit_en(mask_b),
        .o_s_idx(idx_b), .o_digit_sel(sel_b), .o_blank(blank_b), .o_frame(frame_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int d, input bit rst, input bit en, input int mask);
        int nd;
        int nxt;
        int s;
        bit found;
        nd = c_digits[d];
        if (rst) begin
            m_mode[d] = 0; m_idx[d] = 0; m_age[d] = 0; m_frame[d] = 0;
        end else if (!en || mask == 0) begin
            m_mode[d] = 0; m_frame[d] = 0;
        end else if (m_mode[d] == 0) begin
            m_mode[d] = 1; m_age[d] = 0; m_frame[d] = 1;
            m_idx[d] = 0;
            while (((mask >> m_idx[d]) & 1) == 0) m_idx[d]++;
        end else if (m_mode[d] == 1) begin
            m_frame[d] = 0;
            if (m_age[d] == c_div[d] - 1) begin
                nxt = m_idx[d];
                found = 0;
                for (int k = 1; k <= nd; k++) begin
                    int p;
                    p = (m_idx[d] + k) % nd;
                    if (!found && ((mask >> p) & 1) != 0) begin
                        nxt = p;
                        found = 1;
                    end
                end
                m_frame[d] = (nxt <= m_idx[d]);
                m_idx[d]   = nxt;
                m_age[d]   = 0;
                m_mode[d]  = (c_bt[d] > 0) ? 2 : 1;
            end else begin
                m_age[d]++;
            end
        end else begin
            m_frame[d] = 0;
            if (m_age[d] == c_bt[d] * c_div[d] - 1) begin
                m_mode[d] = 1; m_age[d] = 0;
            end else begin
                m_age[d]++;
            end
        end
        s = (m_mode[d] == 1 && ((mask >> m_idx[d]) & 1) != 0) ? (1 << m_idx[d]) : 0;
        if (c_al[d] != 0) s = ~s & ((1 << nd) - 1);
        m_sel[d] = s;
    endtask

    // One clock: inputs seen at the edge drive the model, outputs sampled 1ns later.
    task automatic cyc();
        bit ra, ea, rb, eb;
        int ma, mb;
        ra = rst_a; ea = en_a; ma = int'(mask_a);
        rb = rst_b; eb = en_b; mb = int'(mask_b);
        @(posedge clk);
        model_step(0, ra, ea, ma);
        model_step(1, rb, eb, mb);
        #1;
        check("a_idx",   idx_a,   m_idx[0]);
        check("a_sel",   sel_a,   m_sel[0]);
        check("a_blank", blank_a, m_mode[0] != 1);
        check("a_frame", frame_a, m_frame[0]);
        check("b_idx",   idx_b,   m_idx[1]);
        check("b_sel",   sel_b,   m_sel[1]);
        check("b_blank", blank_b, m_mode[1] != 1);
        check("b_frame", frame_b, m_frame[1]);
    endtask

    int a_idx_t [5]  = '{0, 1, 2, 0, 1};
    int a_frm_t [5]  = '{1, 0, 0, 1, 0};
    int a_sel_t [5]  = '{1, 2, 4, 1, 2};
    int b_idx_t [10] = '{1, 1, 1, 1, 3, 3, 3, 3, 3, 3};
    int b_blk_t [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        int wait_cnt;
        int dropped;
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_idx[d] = 0; m_age[d] = 0; m_sel[d] = 0; m_frame[d] = 0;
        end
        rst_a = 1'b1; en_a = 1'b1; mask_a = 3'b111;
        rst_b = 1'b1; en_b = 1'b1; mask_b = 4'b1010;

        // Reset held with EN high.
        repeat (3) begin
            cyc();
            check("rst_idx",   idx_b,   0);
            check("rst_sel",   sel_b,   4'b1111);
            check("rst_blank", blank_b, 1);
            check("rst_frame", frame_b, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0;

        // Full-mask one-step-per-cycle scan and masked 1010 scan with gaps.
        for (int i = 0; i < 13; i++) begin
            cyc();
            if (i < 5) begin
                check("seq_a_idx",   idx_a,   a_idx_t[i]);
                check("seq_a_frame", frame_a, a_frm_t[i]);
                check("seq_a_sel",   sel_a,   a_sel_t[i]);
            end
            if (i < 10) begin
                check("seq_b_idx",   idx_b,   b_idx_t[i]);
                check("seq_b_blank", blank_b, b_blk_t[i]);
            end
            if (i == 0)  check("seq_b_frame0", frame_b, 1);
            if (i == 12) begin
                check("wrap_b_frame", frame_b, 1);
                check("wrap_b_idx",   idx_b,   1);
                check("wrap_b_blank", blank_b, 1);
            end
        end

        // Single enabled digit.
        mask_b = 4'b0100;
        repeat (40) cyc();
        check("single_idx", idx_b, 2);

        // Drop the lit digit's mask bit mid-ON, then clear the whole mask.
        mask_b = 4'b1111;
        wait_cnt = 0;
        while (!(m_mode[1] == 1 && m_age[1] == 1) && wait_cnt < 50) begin
            cyc();
            wait_cnt++;
        end
        check("wait_mid_on", wait_cnt < 50, 1);
        dropped = m_idx[1];
        mask_b[dropped] = 1'b0;
        cyc();
        check("drop_sel",   sel_b,   4'b1111);
        check("drop_blank", blank_b, 0);
        check("drop_idx",   idx_b,   dropped);
        repeat (12) cyc();
        mask_b = 4'b0000;
        cyc();
        check("off_blank", blank_b, 1);
        check("off_sel",   sel_b,   4'b1111);
        repeat (3) cyc();

        // EN low for 10 cycles, then restart from the lowest enabled digit.
        mask_b = 4'b1010;
        repeat (12) cyc();
        en_b = 1'b0;
        repeat (10) cyc();
        check("en_low_blank", blank_b, 1);
        en_b = 1'b1;
        cyc();
        check("restart_frame", frame_b, 1);
        check("restart_idx",   idx_b,   1);
        repeat (3) cyc();
        check("restart_on", blank_b, 0);
        cyc();
        check("restart_gap", blank_b, 1);

        // Randomised enables, masks and occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            rst_a = ($urandom_range(0, 40) == 0);
            rst_b = ($urandom_range(0, 40) == 0);
            en_a  = ($urandom_range(0, 15) != 0);
            en_b  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) mask_a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) mask_b = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
